// File: rtl/ula_bus_ctrl_if.sv
// ============================================================================
// Module      : ula_bus_ctrl_if
// Description : Request/response handshake and shared result bus bundle for
//               the ULA bus sequencer.
//               slave  modport : controller view (ula_bus_ctrl)
//               master modport : requester + functional-unit view
//               req_valid/req_ready/req_op/req_a/req_b : request handshake
//               op_a/op_b      : registered operands broadcast to all units
//               en             : one-hot three-state enables (NUM_UNITS wide)
//               bus            : shared 9-bit result bus (bit 8 = carry/borrow)
//               rsp_valid/rsp_ready/rsp_data/rsp_err : response handshake
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ula_bus_ctrl_if #(
  parameter int NUM_UNITS = 6
);
  logic                 req_valid;
  logic                 req_ready;
  logic [2:0]           req_op;
  logic [7:0]           req_a;
  logic [7:0]           req_b;
  logic [7:0]           op_a;
  logic [7:0]           op_b;
  logic [NUM_UNITS-1:0] en;
  logic [8:0]           bus;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [8:0]           rsp_data;
  logic                 rsp_err;

  modport slave (
    input  req_valid, req_op, req_a, req_b, bus, rsp_ready,
    output req_ready, op_a, op_b, en, rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_op, req_a, req_b, bus, rsp_ready,
    input  req_ready, op_a, op_b, en, rsp_valid, rsp_data, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/ula_bus_ctrl.sv
// ============================================================================
// Module      : ula_bus_ctrl
// Description : Sequencer for the ULA shared 9-bit result bus. Accepts one
//               request at a time, broadcasts the operands, enables exactly
//               one functional unit for SETTLE cycles, captures the bus and
//               returns it over a valid/ready response handshake.
//               Ports: clk   - rising-edge clock
//                      rst_n - asynchronous active-low reset
//                      ulab  - ula_bus_ctrl_if.slave (request, operands,
//                              enables, bus, response); its NUM_UNITS must
//                              match this module's NUM_UNITS.
//               Parameters: NUM_UNITS (1..8), SETTLE (1..15)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ula_bus_ctrl #(
  parameter int NUM_UNITS = 6,
  parameter int SETTLE    = 1
) (
  input wire logic      clk,
  input wire logic      rst_n,
  ula_bus_ctrl_if.slave ulab
);

  localparam logic [3:0] C_NUM_UNITS   = 4'(NUM_UNITS);
  localparam logic [3:0] C_SETTLE_LOAD = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  // Held low through reset and for the first edge after it, so req_ready
  // only rises on the first clock edge after rst_n is released.
  logic                 r_rdy;
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_nxt;
  logic [7:0]           r_op_a;
  logic [7:0]           w_op_a_nxt;
  logic [7:0]           r_op_b;
  logic [7:0]           w_op_b_nxt;
  // The enable register doubles as the latched op code: it is loaded with
  // the one-hot decode at acceptance and held for the whole DRIVE window.
  logic [NUM_UNITS-1:0] r_en;
  logic [NUM_UNITS-1:0] w_en_nxt;
  logic [8:0]           r_data;
  logic [8:0]           w_data_nxt;
  logic                 r_err;
  logic                 w_err_nxt;
  logic                 w_accept;

  assign w_accept = (r_state == IDLE) && r_rdy && ulab.req_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_a_nxt  = r_op_a;
    w_op_b_nxt  = r_op_b;
    w_en_nxt    = r_en;
    w_data_nxt  = r_data;
    w_err_nxt   = r_err;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_op_a_nxt = ulab.req_a;
          w_op_b_nxt = ulab.req_b;
          if ({1'b0, ulab.req_op} < C_NUM_UNITS) begin
            w_state_nxt = DRIVE;
            w_cnt_nxt   = C_SETTLE_LOAD;
            for (int i = 0; i < NUM_UNITS; i++) begin
              w_en_nxt[i] = (ulab.req_op == 3'(i));
            end
          end else begin
            // Illegal op: respond with an error, never touch the bus.
            w_state_nxt = RESP;
            w_data_nxt  = 9'h000;
            w_err_nxt   = 1'b1;
          end
        end
      end

      DRIVE: begin
        if (r_cnt == 4'd0) begin
          // Last settle cycle: capture the bus and release the enable on
          // the same edge so RESP is always an en=0 cycle.
          w_data_nxt  = ulab.bus;
          w_err_nxt   = 1'b0;
          w_en_nxt    = '0;
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end

      RESP: begin
        if (ulab.rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_en_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rdy   <= 1'b0;
      r_cnt   <= 4'd0;
      r_op_a  <= 8'h00;
      r_op_b  <= 8'h00;
      r_en    <= '0;
      r_data  <= 9'h000;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rdy   <= 1'b1;
      r_cnt   <= w_cnt_nxt;
      r_op_a  <= w_op_a_nxt;
      r_op_b  <= w_op_b_nxt;
      r_en    <= w_en_nxt;
      r_data  <= w_data_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign ulab.req_ready = (r_state == IDLE) && r_rdy;
  assign ulab.rsp_valid = (r_state == RESP);
  assign ulab.op_a      = r_op_a;
  assign ulab.op_b      = r_op_b;
  assign ulab.en        = r_en;
  assign ulab.rsp_data  = r_data;
  assign ulab.rsp_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ula_bus_ctrl.sv
// ============================================================================
// Module      : tb_ula_bus_ctrl
// Description : Self-checking bench for ula_bus_ctrl. Three controllers with
//               SETTLE = 1, 2, 3 each drive their own bus model; every one is
//               watched for multi-hot enables, missing idle gaps and wrong
//               enable window lengths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ula_bus_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [2:0]       req_valid;
  logic [2:0]       rsp_ready;
  logic [2:0][2:0]  req_op;
  logic [2:0][7:0]  req_a;
  logic [2:0][7:0]  req_b;
  logic [2:0]       req_ready_s;
  logic [2:0]       rsp_valid_s;
  logic [2:0]       rsp_err_s;
  logic [2:0][7:0]  op_a_s;
  logic [2:0][7:0]  op_b_s;
  logic [2:0][5:0]  en_s;
  logic [2:0][8:0]  rsp_data_s;

  int total = 0;
  int bad   = 0;

  // Reference functional units: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A.
  function automatic logic [8:0] alu(input logic [2:0] op, input logic [7:0] a,
                                     input logic [7:0] b);
    case (op)
      3'd0:    alu = {1'b0, a} + {1'b0, b};
      3'd1:    alu = {1'b0, a} - {1'b0, b};
      3'd2:    alu = {1'b0, a & b};
      3'd3:    alu = {1'b0, a | b};
      3'd4:    alu = {1'b0, a ^ b};
      3'd5:    alu = {1'b0, ~a};
      default: alu = 9'h000;
    endcase
  endfunction

  // Bus shows the unit result only once the enable has been held SETTLE
  // cycles; before that it shows the complement, and idle/contention values
  // are distinct junk.
  function automatic logic [8:0] bus_model(input logic [5:0] e, input logic [7:0] a,
                                           input logic [7:0] b, input logic [3:0] age,
                                           input int s);
    logic [8:0] v;
    v = 9'h000;
    for (int i = 0; i < 6; i++) if (e[i]) v = alu(3'(i), a, b);
    if (e == 6'd0) return 9'h1AA;
    if ($countones(e) != 1) return 9'h000;
    if (int'(age) != s - 1) return ~v;
    return v;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int S = k + 1;
    ula_bus_ctrl_if #(.NUM_UNITS(6)) ulab ();
    logic [3:0] age  = 4'd0;
    int         run  = 0;
    logic [5:0] prev = 6'd0;

    assign ulab.req_valid = req_valid[k];
    assign ulab.req_op    = req_op[k];
    assign ulab.req_a     = req_a[k];
    assign ulab.req_b     = req_b[k];
    assign ulab.rsp_ready = rsp_ready[k];
    assign ulab.bus       = bus_model(ulab.en, ulab.op_a, ulab.op_b, age, S);
    assign req_ready_s[k] = ulab.req_ready;
    assign rsp_valid_s[k] = ulab.rsp_valid;
    assign rsp_err_s[k]   = ulab.rsp_err;
    assign op_a_s[k]      = ulab.op_a;
    assign op_b_s[k]      = ulab.op_b;
    assign en_s[k]        = ulab.en;
    assign rsp_data_s[k]  = ulab.rsp_data;

    ula_bus_ctrl #(.NUM_UNITS(6), .SETTLE(S)) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .ulab (ulab)
    );

    always @(posedge clk) age <= (ulab.en == 6'd0) ? 4'd0 : ((age == 4'hF) ? age : age + 4'd1);

    always @(negedge clk) begin
      if (!rst_n) begin
        run  = 0;
        prev = 6'd0;
      end else begin
        total++;
        if ($countones(ulab.en) > 1) begin
          bad++;
          $display("FAIL onehot[%0d]: en=%b required at most one bit", k, ulab.en);
        end
        if (ulab.en != 6'd0) begin
          if (prev != 6'd0) begin
            total++;
            if (prev != ulab.en) begin
              bad++;
              $display("FAIL gap[%0d]: en %b followed %b with no idle cycle", k, ulab.en, prev);
            end
          end
          run++;
        end else if (run != 0) begin
          total++;
          if (run != S) begin
            bad++;
            $display("FAIL window[%0d]: en held %0d cycles, required %0d", k, run, S);
          end
          run = 0;
        end
        prev = ulab.en;
      end
    end
  end

  task automatic test_reset();
    logic seen;
    repeat (3) @(negedge clk);
    total++;
    if (req_ready_s !== 3'b000 || en_s[2] !== 6'd0 || rsp_valid_s !== 3'b000) begin
      bad++;
      $display("FAIL reset_ctrl: ready=%b en=%b valid=%b required 000/0/000", req_ready_s, en_s[2], rsp_valid_s);
    end
    total++;
    if (rsp_err_s[2] !== 1'b0 || rsp_data_s[2] !== 9'h000 || op_a_s[2] !== 8'h00 || op_b_s[2] !== 8'h00) begin
      bad++;
      $display("FAIL reset_data: err=%b data=%h a=%h b=%h required zeros", rsp_err_s[2], rsp_data_s[2], op_a_s[2], op_b_s[2]);
    end
    @(posedge clk); #2 rst_n = 1'b1; #1;
    total++;
    if (req_ready_s !== 3'b000) begin
      bad++;
      $display("FAIL ready_at_release: ready=%b required 000", req_ready_s);
    end
    @(negedge clk); @(negedge clk);
    total++;
    if (req_ready_s !== 3'b111) begin
      bad++;
      $display("FAIL ready_after_edge: ready=%b required 111", req_ready_s);
    end
    // Reset in the middle of a SETTLE=3 drive window.
    req_valid[2] = 1'b1; req_op[2] = 3'd2; req_a[2] = 8'h5A; req_b[2] = 8'h3C;
    @(negedge clk);
    req_valid[2] = 1'b0;
    total++;
    if (en_s[2] !== 6'b000100 || op_a_s[2] !== 8'h5A || op_b_s[2] !== 8'h3C) begin
      bad++;
      $display("FAIL drive_start: en=%b a=%h b=%h required 000100/5a/3c", en_s[2], op_a_s[2], op_b_s[2]);
    end
    @(negedge clk);
    #2 rst_n = 1'b0; #1;
    total++;
    if (en_s[2] !== 6'd0 || rsp_valid_s[2] !== 1'b0 || op_a_s[2] !== 8'h00 || op_b_s[2] !== 8'h00 || req_ready_s[2] !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: en=%b valid=%b a=%h b=%h ready=%b required all zero",
               en_s[2], rsp_valid_s[2], op_a_s[2], op_b_s[2], req_ready_s[2]);
    end
    @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1; #1;
    total++;
    if (req_ready_s[2] !== 1'b0) begin
      bad++;
      $display("FAIL ready_at_release2: ready=%b required 0", req_ready_s[2]);
    end
    @(negedge clk); @(negedge clk);
    total++;
    if (req_ready_s[2] !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset: ready=%b required 1", req_ready_s[2]);
    end
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid_s[2] || en_s[2] != 6'd0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL no_response: activity=%b after reset, required 0", seen);
    end
  endtask

  task automatic test_or();
    @(negedge clk);
    rsp_ready[0] = 1'b1;
    req_valid[0] = 1'b1; req_op[0] = 3'd3; req_a[0] = 8'hF0; req_b[0] = 8'h0F;
    total++;
    if (req_ready_s[0] !== 1'b1) begin
      bad++;
      $display("FAIL or_ready: ready=%b required 1", req_ready_s[0]);
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    total++;
    if (en_s[0] !== 6'b001000 || rsp_valid_s[0] !== 1'b0 || op_a_s[0] !== 8'hF0 || op_b_s[0] !== 8'h0F) begin
      bad++;
      $display("FAIL or_drive: en=%b valid=%b a=%h b=%h required 001000/0/f0/0f",
               en_s[0], rsp_valid_s[0], op_a_s[0], op_b_s[0]);
    end
    @(negedge clk);
    total++;
    if (en_s[0] !== 6'd0 || rsp_valid_s[0] !== 1'b1 || rsp_data_s[0] !== 9'h0FF || rsp_err_s[0] !== 1'b0) begin
      bad++;
      $display("FAIL or_rsp: en=%b valid=%b data=%h err=%b required 0/1/0ff/0",
               en_s[0], rsp_valid_s[0], rsp_data_s[0], rsp_err_s[0]);
    end
    @(negedge clk);
    total++;
    if (rsp_valid_s[0] !== 1'b0 || req_ready_s[0] !== 1'b1) begin
      bad++;
      $display("FAIL or_idle: valid=%b ready=%b required 0/1", rsp_valid_s[0], req_ready_s[0]);
    end
  endtask

  task automatic test_carry();
    @(negedge clk);
    rsp_ready[1] = 1'b1;
    req_valid[1] = 1'b1; req_op[1] = 3'd0; req_a[1] = 8'hFF; req_b[1] = 8'h01;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      req_valid[1] = 1'b0;
      total++;
      if (en_s[1] !== 6'b000001 || rsp_valid_s[1] !== 1'b0) begin
        bad++;
        $display("FAIL carry_drive%0d: en=%b valid=%b required 000001/0", c, en_s[1], rsp_valid_s[1]);
      end
    end
    @(negedge clk);
    total++;
    if (en_s[1] !== 6'd0 || rsp_valid_s[1] !== 1'b1 || rsp_data_s[1] !== 9'h100 || rsp_err_s[1] !== 1'b0) begin
      bad++;
      $display("FAIL carry_rsp: en=%b valid=%b data=%h err=%b required 0/1/100/0",
               en_s[1], rsp_valid_s[1], rsp_data_s[1], rsp_err_s[1]);
    end
    @(negedge clk);
    total++;
    if (rsp_valid_s[1] !== 1'b0 || req_ready_s[1] !== 1'b1) begin
      bad++;
      $display("FAIL carry_idle: valid=%b ready=%b required 0/1", rsp_valid_s[1], req_ready_s[1]);
    end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    rsp_ready[0] = 1'b1;
    req_valid[0] = 1'b1; req_op[0] = 3'd7; req_a[0] = 8'h33; req_b[0] = 8'h44;
    @(negedge clk);
    req_valid[0] = 1'b0;
    total++;
    if (en_s[0] !== 6'd0 || rsp_valid_s[0] !== 1'b1 || rsp_err_s[0] !== 1'b1 || rsp_data_s[0] !== 9'h000) begin
      bad++;
      $display("FAIL illegal_rsp: en=%b valid=%b err=%b data=%h required 0/1/1/000",
               en_s[0], rsp_valid_s[0], rsp_err_s[0], rsp_data_s[0]);
    end
    total++;
    if (op_a_s[0] !== 8'h33 || op_b_s[0] !== 8'h44) begin
      bad++;
      $display("FAIL illegal_operands: a=%h b=%h required 33/44", op_a_s[0], op_b_s[0]);
    end
    @(negedge clk);
    total++;
    if (en_s[0] !== 6'd0 || rsp_valid_s[0] !== 1'b0 || req_ready_s[0] !== 1'b1) begin
      bad++;
      $display("FAIL illegal_idle: en=%b valid=%b ready=%b required 0/0/1", en_s[0], rsp_valid_s[0], req_ready_s[0]);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    rsp_ready[1] = 1'b0;
    req_valid[1] = 1'b1; req_op[1] = 3'd4; req_a[1] = 8'hA5; req_b[1] = 8'h0F;
    @(negedge clk);
    // Second request stays pending for the whole busy period.
    req_op[1] = 3'd1; req_a[1] = 8'h10; req_b[1] = 8'h20;
    @(negedge clk); @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      total++;
      if (rsp_valid_s[1] !== 1'b1 || rsp_data_s[1] !== 9'h0AA || rsp_err_s[1] !== 1'b0 ||
          req_ready_s[1] !== 1'b0 || en_s[1] !== 6'd0 || op_a_s[1] !== 8'hA5) begin
        bad++;
        $display("FAIL bp_hold%0d: valid=%b data=%h err=%b ready=%b en=%b a=%h required 1/0aa/0/0/0/a5",
                 c, rsp_valid_s[1], rsp_data_s[1], rsp_err_s[1], req_ready_s[1], en_s[1], op_a_s[1]);
      end
      @(negedge clk);
    end
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    total++;
    if (rsp_valid_s[1] !== 1'b0 || req_ready_s[1] !== 1'b1 || en_s[1] !== 6'd0 || op_a_s[1] !== 8'hA5) begin
      bad++;
      $display("FAIL bp_release: valid=%b ready=%b en=%b a=%h required 0/1/0/a5",
               rsp_valid_s[1], req_ready_s[1], en_s[1], op_a_s[1]);
    end
    @(negedge clk);
    req_valid[1] = 1'b0;
    total++;
    if (en_s[1] !== 6'b000010 || op_a_s[1] !== 8'h10 || op_b_s[1] !== 8'h20) begin
      bad++;
      $display("FAIL bp_second: en=%b a=%h b=%h required 000010/10/20", en_s[1], op_a_s[1], op_b_s[1]);
    end
    @(negedge clk); @(negedge clk);
    total++;
    if (rsp_valid_s[1] !== 1'b1 || rsp_data_s[1] !== 9'h1F0 || rsp_err_s[1] !== 1'b0) begin
      bad++;
      $display("FAIL bp_second_rsp: valid=%b data=%h err=%b required 1/1f0/0",
               rsp_valid_s[1], rsp_data_s[1], rsp_err_s[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_q[$];
    logic [9:0] exp_v;
    logic [9:0] got;
    logic       pending;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int sent;
    int rcvd;
    int cyc;
    pending = 1'b0; sent = 0; rcvd = 0; cyc = 0; op = 3'd0; a = 8'h00; b = 8'h00;
    while ((sent < 200 || rcvd < 200) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      rsp_ready[1] = ($urandom_range(0, 2) != 0);
      if (rsp_valid_s[1] && rsp_ready[1]) begin
        total++;
        got = {rsp_err_s[1], rsp_data_s[1]};
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra: unexpected response err/data=%h", got);
        end else begin
          exp_v = exp_q.pop_front();
          if (got !== exp_v) begin
            bad++;
            $display("FAIL b2b_rsp%0d: err/data=%h required %h", rcvd, got, exp_v);
          end
        end
        rcvd++;
      end
      if (!pending) begin
        req_valid[1] = 1'b0;
        if (sent < 200 && $urandom_range(0, 3) != 0) begin
          op = 3'($urandom_range(0, 7));
          a  = 8'($urandom);
          b  = 8'($urandom);
          req_op[1] = op; req_a[1] = a; req_b[1] = b;
          req_valid[1] = 1'b1;
          pending = 1'b1;
        end
      end
      if (pending && req_ready_s[1]) begin
        exp_q.push_back((op < 3'd6) ? {1'b0, alu(op, a, b)} : {1'b1, 9'h000});
        sent++;
        pending = 1'b0;
      end
    end
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b1;
    total++;
    if (sent != 200 || rcvd != 200 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_count: sent=%0d received=%0d left=%0d required 200/200/0", sent, rcvd, exp_q.size());
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    test_reset();
    test_or();
    test_carry();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
